// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data memory port initiator: one load/store at a time, registered bus, extended responses
module load_store_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [1:0]            WE_o,
    output logic [DATA_WIDTH-1:0] A_o,
    output logic [DATA_WIDTH-1:0] WD_o,
    input  logic [DATA_WIDTH-1:0] RD_i
);

    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [2:0]            funct3_q, funct3_n;
    logic [1:0]            we_n;
    logic [DATA_WIDTH-1:0] a_n, wd_n, rdata_n, ext;
    logic                  valid_n, err_n;
    logic                  legal, misaligned;
    logic [1:0]            store_we;

    assign req_ready_o = (state == IDLE);

    // funct3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word
    always_comb begin
        legal      = 1'b1;
        misaligned = 1'b0;
        store_we   = 2'b01;
        if (req_we_i) begin
            if (req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11))
                legal = 1'b0;
        end else begin
            if ((req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11))
                legal = 1'b0;
        end
        if ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
            misaligned = 1'b1;
        if ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00))
            misaligned = 1'b1;
        case (req_funct3_i[1:0])
            2'b00:   store_we = 2'b11;
            2'b01:   store_we = 2'b10;
            default: store_we = 2'b01;
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'b000:  ext = {{(DATA_WIDTH-8){RD_i[7]}}, RD_i[7:0]};
            3'b001:  ext = {{(DATA_WIDTH-16){RD_i[15]}}, RD_i[15:0]};
            3'b100:  ext = {{(DATA_WIDTH-8){1'b0}}, RD_i[7:0]};
            3'b101:  ext = {{(DATA_WIDTH-16){1'b0}}, RD_i[15:0]};
            default: ext = RD_i;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        funct3_n = funct3_q;
        we_n     = 2'b00;
        a_n      = A_o;
        wd_n     = WD_o;
        valid_n  = 1'b0;
        rdata_n  = resp_rdata_o;
        err_n    = resp_err_o;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    funct3_n = req_funct3_i;
                    if (!legal || misaligned) begin
                        state_n = RESP;
                        valid_n = 1'b1;
                        err_n   = 1'b1;
                        rdata_n = '0;
                    end else if (req_we_i) begin
                        state_n = WRITE;
                        we_n    = store_we;
                        a_n     = req_addr_i;
                        wd_n    = req_wdata_i;
                    end else begin
                        state_n = READ;
                        a_n     = req_addr_i;
                        cnt_n   = CW'(READ_LATENCY - 1);
                    end
                end
            end
            WRITE: begin
                state_n = RESP;
                valid_n = 1'b1;
                err_n   = 1'b0;
                rdata_n = '0;
            end
            READ: begin
                if (cnt == '0) begin
                    state_n = RESP;
                    valid_n = 1'b1;
                    err_n   = 1'b0;
                    rdata_n = ext;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // async clear drops WE_o at once so an interrupted store never commits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            funct3_q     <= '0;
            WE_o         <= 2'b00;
            A_o          <= '0;
            WD_o         <= '0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            funct3_q     <= funct3_n;
            WE_o         <= we_n;
            A_o          <= a_n;
            WD_o         <= wd_n;
            resp_valid_o <= valid_n;
            resp_rdata_o <= rdata_n;
            resp_err_o   <= err_n;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  we;
    logic [31:0] a, wd, rd;

    logic        req_valid3, req_ready3, resp_valid3, resp_err3;
    logic [31:0] resp_rdata3, a3, wd3, rd3;
    logic [1:0]  we3;

    logic [7:0]  mem [16];
    logic [3:0]  ai;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] r_rdata, r_wd_val;
    logic        r_err, r_pulse;
    logic [1:0]  r_we_val;
    int          r_edges, r_we_cnt;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .READ_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .WE_o(we), .A_o(a), .WD_o(wd), .RD_i(rd)
    );

    load_store_unit #(.DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_we_i(1'b0),
        .req_funct3_i(3'b010), .req_addr_i(32'h0001_0000), .req_wdata_i(32'h0),
        .resp_valid_o(resp_valid3), .resp_rdata_o(resp_rdata3), .resp_err_o(resp_err3),
        .WE_o(we3), .A_o(a3), .WD_o(wd3), .RD_i(rd3)
    );

    assign ai  = a[3:0];
    assign rd  = {mem[ai + 4'd3], mem[ai + 4'd2], mem[ai + 4'd1], mem[ai]};
    assign rd3 = a3 ^ 32'hFFFF_0000;

    always @(posedge clk) begin
        case (we)
            2'b01: begin
                mem[ai] <= wd[7:0];          mem[ai + 4'd1] <= wd[15:8];
                mem[ai + 4'd2] <= wd[23:16]; mem[ai + 4'd3] <= wd[31:24];
            end
            2'b10: begin
                mem[ai] <= wd[7:0];          mem[ai + 4'd1] <= wd[15:8];
            end
            2'b11: mem[ai] <= wd[7:0];
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] ad,
                          input logic [31:0] dat);
        int waits;
        @(negedge clk);
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        req_valid = 1'b1; req_we = w; req_funct3 = f3; req_addr = ad; req_wdata = dat;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_edges = 1; r_we_cnt = 0; r_we_val = 2'b00; r_wd_val = 32'h0;
        while (!resp_valid && r_edges < 20) begin
            if (we != 2'b00) begin
                r_we_cnt++; r_we_val = we; r_wd_val = wd;
            end
            @(posedge clk); #1;
            r_edges++;
        end
        r_rdata = resp_rdata; r_err = resp_err;
        @(posedge clk); #1;
        r_pulse = resp_valid;
    endtask

    initial begin
        logic [4:0] vpat, rpat;
        logic       ready_seen;
        int         e;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        req_valid3 = 0;
        #2;
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err_we", {29'b0, resp_err, we}, 32'h0);
        check("rst_a_wd", a | wd, 32'h0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        do_req(1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF);
        check("sw_edges", r_edges, 32'd2);
        check("sw_we_cycles", r_we_cnt, 32'd1);
        check("sw_we", {30'b0, r_we_val}, 32'h1);
        check("sw_wd", r_wd_val, 32'hDEAD_BEEF);
        check("sw_err_rdata", {r_err, r_rdata[30:0]} | r_rdata, 32'h0);
        check("sw_pulse", {31'b0, r_pulse}, 32'h0);
        do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0);
        check("lw_edges", r_edges, 32'd2);
        check("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        check("lw_err", {31'b0, r_err}, 32'h0);

        do_req(1'b1, 3'b010, 32'h0001_0000, 32'h0000_80F0);
        do_req(1'b0, 3'b000, 32'h0001_0000, 32'h0);
        check("lb", r_rdata, 32'hFFFF_FFF0);
        do_req(1'b0, 3'b100, 32'h0001_0000, 32'h0);
        check("lbu", r_rdata, 32'h0000_00F0);
        do_req(1'b0, 3'b001, 32'h0001_0000, 32'h0);
        check("lh", r_rdata, 32'hFFFF_80F0);
        do_req(1'b0, 3'b101, 32'h0001_0000, 32'h0);
        check("lhu", r_rdata, 32'h0000_80F0);

        do_req(1'b1, 3'b001, 32'h0001_0002, 32'h1234_ABCD);
        check("sh_we", {30'b0, r_we_val}, 32'h2);
        check("sh_wd", r_wd_val, 32'h1234_ABCD);
        do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0);
        check("sh_lw", r_rdata, 32'hABCD_80F0);
        do_req(1'b0, 3'b001, 32'h0001_0002, 32'h0);
        check("lh_hi", r_rdata, 32'hFFFF_ABCD);
        do_req(1'b0, 3'b100, 32'h0001_0003, 32'h0);
        check("lbu_odd", r_rdata, 32'h0000_00AB);

        do_req(1'b0, 3'b010, 32'h0001_0001, 32'h0);
        check("mis_lw", {r_err, 23'b0, r_edges[7:0]}, 32'h8000_0001);
        do_req(1'b0, 3'b001, 32'h0001_0003, 32'h0);
        check("mis_lh", {r_err, 23'b0, r_edges[7:0]}, 32'h8000_0001);
        do_req(1'b1, 3'b010, 32'h0001_0002, 32'h5555_5555);
        check("mis_sw", {r_err, 23'b0, r_edges[7:0]}, 32'h8000_0001);
        check("mis_sw_we", r_we_cnt, 32'd0);
        do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0);
        check("mis_mem", r_rdata, 32'hABCD_80F0);

        do_req(1'b0, 3'b011, 32'h0001_0000, 32'h0);
        check("ill_ld", {r_err, r_rdata[30:0]} | {1'b0, r_rdata[31], 30'b0}, 32'h8000_0000);
        do_req(1'b1, 3'b100, 32'h0001_0000, 32'h7777_7777);
        check("ill_st", {r_err, r_rdata[30:0]} | {1'b0, r_rdata[31], 30'b0}, 32'h8000_0000);
        check("ill_st_we", r_we_cnt, 32'd0);

        @(negedge clk);
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        e = 1; ready_seen = 1'b0;
        while (!resp_valid3 && e < 20) begin
            ready_seen |= req_ready3;
            @(posedge clk); #1;
            e++;
        end
        ready_seen |= req_ready3;
        check("rl3_edges", e, 32'd4);
        check("rl3_ready_low", {31'b0, ready_seen}, 32'h0);
        check("rl3_rdata", resp_rdata3, 32'hFFFE_0000);

        do_req(1'b1, 3'b010, 32'h0001_0004, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h0001_0005; req_wdata = 32'h0000_00AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("sb_we", {30'b0, we}, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_we", {30'b0, we}, 32'h0);
        check("rstmid_a_wd", a | wd, 32'h0);
        check("rstmid_ready_valid", {30'b0, req_ready, resp_valid}, 32'h2);
        @(negedge clk); rst_n = 1'b1;
        vpat = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vpat[i] = resp_valid;
        end
        check("rstmid_no_resp", {27'b0, vpat}, 32'h0);
        do_req(1'b0, 3'b010, 32'h0001_0004, 32'h0);
        check("rstmid_mem", r_rdata, 32'h1122_3344);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0001_0000;
        vpat = '0; rpat = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vpat[i] = resp_valid;
            rpat[i] = req_ready;
            if (i == 3) req_valid = 1'b0;
        end
        check("b2b_valid", {27'b0, vpat}, 32'h12);
        check("b2b_ready", {27'b0, rpat}, 32'h04);
        check("b2b_rdata", resp_rdata, 32'hABCD_80F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
